n_channel_servo_slew_controller: RTL and testbench

N_CHANNEL_SERVO_SLEW_CONTROLLER -- requirements
Module: n_channel_servo_slew_controller

---
 rtl/n_channel_servo_slew_controller.sv | 139 +++++++++++++
 tb/tb_n_channel_servo_slew_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/n_channel_servo_slew_controller.sv
// n_channel_servo_slew_controller: frame-synchronous N-channel servo PWM
// with per-channel target/applied duty and optional per-frame slew limit.
// Ports:
//   CLOCK, RESET            sole clock, synchronous active-high reset
//   LOAD_SIGNAL             write strobe
//   SERVO_SELECTOR          channel index for the write
//   DUTY_CYCLE_CONTROL      new target duty code
//   PWM_SIGNALS             registered PWM output, one bit per channel
//   LOAD_ACCEPTED           one-cycle pulse after an in-range write
//   LOAD_ERROR              one-cycle pulse after an out-of-range write
//   FRAME_START             one-cycle pulse after each frame boundary
//   CHANNEL_SETTLED         bit i set when applied[i] == target[i]
module n_channel_servo_slew_controller #(
  parameter int NO_OF_CHANNEL    = 4,
  parameter int ADDRESS_WIDTH    =
    (NO_OF_CHANNEL > 1) ? $clog2(NO_OF_CHANNEL) : 1,
  parameter int DUTY_CYCLE_WIDTH = 8,
  parameter int CLKS_PER_TICK    = 50,
  parameter int FRAME_TICKS      = 20000,
  parameter int MIN_PULSE_TICKS  = 1000,
  parameter int STEP_TICKS       = 4,
  parameter int SLEW_STEP        = 0,
  parameter int RESET_DUTY       = 2 ** (DUTY_CYCLE_WIDTH - 1)
) (
  input  logic                        CLOCK,
  input  logic                        RESET,
  input  logic                        LOAD_SIGNAL,
  input  logic [ADDRESS_WIDTH-1:0]    SERVO_SELECTOR,
  input  logic [DUTY_CYCLE_WIDTH-1:0] DUTY_CYCLE_CONTROL,
  output logic [NO_OF_CHANNEL-1:0]    PWM_SIGNALS,
  output logic                        LOAD_ACCEPTED,
  output logic                        LOAD_ERROR,
  output logic                        FRAME_START,
  output logic [NO_OF_CHANNEL-1:0]    CHANNEL_SETTLED
);

  localparam int DW = DUTY_CYCLE_WIDTH;
  localparam int TW =
    (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int FW =
    (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(CLKS_PER_TICK - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
  localparam logic [DW-1:0] DUTY_RST   = DW'(RESET_DUTY);

  // A step larger than any possible difference behaves as "unlimited";
  // clamping keeps it representable in the DW+1 bit difference domain.
  localparam int SLEW_CAP =
    (SLEW_STEP > 2 ** DW) ? 2 ** DW : SLEW_STEP;
  localparam logic [DW:0] SLEW = (DW + 1)'(SLEW_CAP);

  logic [TW-1:0] tick_cnt;
  logic [FW-1:0] frame_cnt;
  logic [DW-1:0] target  [NO_OF_CHANNEL];
  logic [DW-1:0] applied [NO_OF_CHANNEL];

  logic tick;
  logic boundary;
  logic sel_ok;
  logic wr_ok;

  assign tick     = (tick_cnt == TICK_LAST);
  assign boundary = tick && (frame_cnt == FRAME_LAST);
  assign sel_ok   = 32'(SERVO_SELECTOR) < NO_OF_CHANNEL;
  assign wr_ok    = LOAD_SIGNAL && sel_ok;

  // Pulse length in ticks for a given applied duty.
  function automatic logic [31:0] width_of(
    input logic [DW-1:0] d
  );
    width_of = MIN_PULSE_TICKS + 32'(d) * STEP_TICKS;
  endfunction

  // Next applied duty: step toward target by at most SLEW,
  // never past it; the extra bit keeps the difference unsigned
  // without wrap.
  function automatic logic [DW-1:0] slew_to(
    input logic [DW-1:0] tg,
    input logic [DW-1:0] ap
  );
    logic [DW:0] t;
    logic [DW:0] a;
    logic [DW:0] d;
    logic [DW:0] s;
    logic        up;
    t  = {1'b0, tg};
    a  = {1'b0, ap};
    up = (t >= a);
    d  = up ? (t - a) : (a - t);
    s  = (d > SLEW) ? SLEW : d;
    slew_to = tg;
    if (SLEW_STEP != 0) begin
      unique case (1'b1)
        up:      slew_to = DW'(a + s);
        default: slew_to = DW'(a - s);
      endcase
    end
  endfunction

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      tick_cnt        <= '0;
      frame_cnt       <= '0;
      FRAME_START     <= 1'b0;
      LOAD_ACCEPTED   <= 1'b0;
      LOAD_ERROR      <= 1'b0;
      PWM_SIGNALS     <= '0;
      CHANNEL_SETTLED <= '1;
      for (int i = 0; i < NO_OF_CHANNEL; i++) begin
        target[i]  <= DUTY_RST;
        applied[i] <= DUTY_RST;
      end
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (tick) begin
        frame_cnt <= (frame_cnt == FRAME_LAST) ?
                     '0 : frame_cnt + FW'(1);
      end
      FRAME_START   <= boundary;
      LOAD_ACCEPTED <= wr_ok;
      LOAD_ERROR    <= LOAD_SIGNAL && !sel_ok;
      for (int i = 0; i < NO_OF_CHANNEL; i++) begin
        // Boundary update reads the pre-write target, so a write
        // landing on the boundary waits one more frame.
        if (boundary) begin
          applied[i] <= slew_to(target[i], applied[i]);
        end
        if (wr_ok && (32'(SERVO_SELECTOR) == i)) begin
          target[i] <= DUTY_CYCLE_CONTROL;
        end
        PWM_SIGNALS[i] <=
          32'(frame_cnt) < width_of(applied[i]);
        CHANNEL_SETTLED[i] <= (applied[i] == target[i]);
      end
    end
  end

endmodule

// File: tb/tb_n_channel_servo_slew_controller.sv
// tb_n_channel_servo_slew_controller: directed scenarios plus random
// writes/resets, checked against a frame-level reference model.
module tb_n_channel_servo_slew_controller;

  localparam int NCH   = 3;
  localparam int DW    = 6;
  localparam int CPT   = 2;
  localparam int FT    = 100;
  localparam int MINP  = 10;
  localparam int STEP  = 1;
  localparam int RDUTY = 32;
  localparam int FCYC  = CPT * FT;
  localparam int NFR   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [1:0]    sel;
  logic [DW-1:0] duty;

  logic [NCH-1:0] pwm0, pwm5, set0, set5;
  logic           acc0, acc5, err0, err5, fs0, fs5;

  always #5 clk = ~clk;

  n_channel_servo_slew_controller #(
    .NO_OF_CHANNEL(NCH), .DUTY_CYCLE_WIDTH(DW),
    .CLKS_PER_TICK(CPT), .FRAME_TICKS(FT),
    .MIN_PULSE_TICKS(MINP), .STEP_TICKS(STEP),
    .SLEW_STEP(0), .RESET_DUTY(RDUTY)
  ) u_s0 (
    .CLOCK(clk), .RESET(rst), .LOAD_SIGNAL(load),
    .SERVO_SELECTOR(sel), .DUTY_CYCLE_CONTROL(duty),
    .PWM_SIGNALS(pwm0), .LOAD_ACCEPTED(acc0),
    .LOAD_ERROR(err0), .FRAME_START(fs0),
    .CHANNEL_SETTLED(set0)
  );

  n_channel_servo_slew_controller #(
    .NO_OF_CHANNEL(NCH), .DUTY_CYCLE_WIDTH(DW),
    .CLKS_PER_TICK(CPT), .FRAME_TICKS(FT),
    .MIN_PULSE_TICKS(MINP), .STEP_TICKS(STEP),
    .SLEW_STEP(5), .RESET_DUTY(RDUTY)
  ) u_s5 (
    .CLOCK(clk), .RESET(rst), .LOAD_SIGNAL(load),
    .SERVO_SELECTOR(sel), .DUTY_CYCLE_CONTROL(duty),
    .PWM_SIGNALS(pwm5), .LOAD_ACCEPTED(acc5),
    .LOAD_ERROR(err5), .FRAME_START(fs5),
    .CHANNEL_SETTLED(set5)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t",
                  tag, got, exp, $time);
  endtask

  // Reference state: k = clock edges since reset released.
  int k;
  int slew_of [2] = '{0, 5};
  int tg  [2][NCH];
  int ap  [2][NCH];
  int cnt [2][NCH];
  int wid [2][NFR][NCH];
  int fidx;

  function automatic int slew_fn(input int t, input int a,
                                 input int s);
    if (s == 0) return t;
    if (t > a) return (t - a > s) ? a + s : t;
    return (a - t > s) ? a - s : t;
  endfunction

  task automatic cyc();
    logic [NCH-1:0] e_pwm [2];
    logic [NCH-1:0] e_set [2];
    logic e_acc, e_err, e_fs;
    int   pos;
    @(posedge clk);
    e_acc = 1'b0;
    e_err = 1'b0;
    e_fs  = 1'b0;
    if (rst) begin
      k = 0;
      for (int d = 0; d < 2; d++) begin
        e_pwm[d] = '0;
        e_set[d] = '1;
        for (int c = 0; c < NCH; c++) begin
          tg[d][c] = RDUTY;
          ap[d][c] = RDUTY;
        end
      end
    end else begin
      k++;
      pos  = (k - 1) % FCYC;
      e_fs = (k % FCYC == 0);
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NCH; c++) begin
          e_pwm[d][c] = pos < CPT * (MINP + STEP * ap[d][c]);
          e_set[d][c] = (ap[d][c] == tg[d][c]);
          if (e_fs)
            ap[d][c] = slew_fn(tg[d][c], ap[d][c], slew_of[d]);
        end
        if (load) begin
          if (int'(sel) < NCH) tg[d][sel] = int'(duty);
        end
      end
      e_acc = load && (int'(sel) < NCH);
      e_err = load && (int'(sel) >= NCH);
    end
    @(negedge clk);
    chk("pwm_s0", 64'(pwm0), 64'(e_pwm[0]));
    chk("pwm_s5", 64'(pwm5), 64'(e_pwm[1]));
    chk("settled_s0", 64'(set0), 64'(e_set[0]));
    chk("settled_s5", 64'(set5), 64'(e_set[1]));
    chk("accept_s0", 64'(acc0), 64'(e_acc));
    chk("accept_s5", 64'(acc5), 64'(e_acc));
    chk("error_s0", 64'(err0), 64'(e_err));
    chk("error_s5", 64'(err5), 64'(e_err));
    chk("fstart_s0", 64'(fs0), 64'(e_fs));
    chk("fstart_s5", 64'(fs5), 64'(e_fs));
    // Measured high time per frame, closed by FRAME_START.
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        cnt[0][c] = 0;
        cnt[1][c] = 0;
      end
    end else begin
      if (fs0) begin
        for (int c = 0; c < NCH; c++) begin
          if (fidx < NFR) begin
            wid[0][fidx][c] = cnt[0][c];
            wid[1][fidx][c] = cnt[1][c];
          end
          cnt[0][c] = 0;
          cnt[1][c] = 0;
        end
        fidx++;
      end
      for (int c = 0; c < NCH; c++) begin
        cnt[0][c] += int'(pwm0[c]);
        cnt[1][c] += int'(pwm5[c]);
      end
    end
  endtask

  task automatic run_to(input int kk);
    int guard = 0;
    while (k < kk && guard < 5000) begin
      cyc();
      guard++;
    end
  endtask

  task automatic wr(input logic [1:0] s, input logic [DW-1:0] v);
    load = 1'b1;
    sel  = s;
    duty = v;
    cyc();
    load = 1'b0;
  endtask

  task automatic chk_frame(input int d, input int f,
                           input int w0, input int w1,
                           input int w2);
    chk($sformatf("width_d%0d_f%0d_c0", d, f), 64'(wid[d][f][0]),
        64'(w0));
    chk($sformatf("width_d%0d_f%0d_c1", d, f), 64'(wid[d][f][1]),
        64'(w1));
    chk($sformatf("width_d%0d_f%0d_c2", d, f), 64'(wid[d][f][2]),
        64'(w2));
  endtask

  int slew_exp [7] = '{47, 52, 57, 62, 67, 72, 73};

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    sel  = '0;
    duty = '0;
    k    = 0;
    fidx = 0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) cnt[d][c] = 0;
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < NFR; f++)
        for (int c = 0; c < NCH; c++) wid[d][f][c] = -1;

    // Load is ignored while in reset.
    load = 1'b1;
    sel  = 2'd1;
    duty = 6'd5;
    repeat (3) cyc();
    load = 1'b0;
    rst  = 1'b0;

    run_to(49);
    wr(2'd1, 6'd0);
    run_to(249);
    wr(2'd3, 6'd7);
    run_to(449);
    wr(2'd0, 6'd63);
    run_to(1999);
    wr(2'd2, 6'd20);
    run_to(2499);
    rst = 1'b1;
    repeat (4) cyc();
    rst = 1'b0;
    run_to(400);

    chk_frame(0, 0, 84, 84, 84);
    chk_frame(0, 1, 84, 20, 84);
    chk_frame(0, 2, 84, 20, 84);
    chk_frame(0, 3, 146, 20, 84);
    for (int f = 0; f < 7; f++)
      chk($sformatf("slew_width_f%0d", f + 3),
          64'(wid[1][f + 3][0]), 64'(2 * slew_exp[f]));
    chk("boundary_wr_f10", 64'(wid[0][10][2]), 64'(84));
    chk("boundary_wr_f11", 64'(wid[0][11][2]), 64'(60));
    chk_frame(0, 12, 84, 84, 84);
    chk_frame(0, 13, 84, 84, 84);
    chk_frame(1, 13, 84, 84, 84);

    for (int n = 0; n < 3000; n++) begin
      load = ($urandom_range(0, 7) == 0);
      sel  = 2'($urandom_range(0, 3));
      duty = DW'($urandom);
      rst  = ($urandom_range(0, 799) == 0);
      cyc();
    end
    load = 1'b0;
    rst  = 1'b0;
    repeat (5) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
